debug_frame_tx: RTL and testbench

Host-link transmitter for the CPU debug ports. On a capture request it snapshots the seven 8-bit debug ports and sends one framed packet to the host serial debugger over a UART line: 8N1, LSB first. It sits between the CPU top level and the board TX pin. It is the sending end of the debug protocol that the host-side debugger parses.

---
 rtl/debug_frame_tx_if.sv | 28 ++
 rtl/debug_frame_tx.sv | 177 +++++++++++++++++
 tb/tb_debug_frame_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_tx_if.sv
// Capture request, snapshot ports and UART status lines between the CPU top level and
// the debug frame transmitter.
interface debug_frame_tx_if;
  logic       capture;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    output capture, debug_port1, debug_port2, debug_port3, debug_port4,
           debug_port5, debug_port6, debug_port7,
    input  tx, busy, frame_done, overrun
  );

  modport slave (
    input  capture, debug_port1, debug_port2, debug_port3, debug_port4,
           debug_port5, debug_port6, debug_port7,
    output tx, busy, frame_done, overrun
  );
endinterface

// File: rtl/debug_frame_tx.sv
// Snapshots seven debug bytes on capture and sends SYNC, p1..p7, XOR checksum
// as one back-to-back 8N1 UART frame, LSB first.
module debug_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic             clk,
  input  logic             nreset,
  debug_frame_tx_if.slave  bus
);

  localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              capture_q;
  logic              load;
  logic              baud_last;
  logic [7:0]        chk_q, chk_d;

  logic [7:0] port_bytes  [1:7];
  logic [7:0] shadow_q    [1:7];
  logic [7:0] frame_bytes [0:15];

  assign port_bytes[1] = bus.debug_port1;
  assign port_bytes[2] = bus.debug_port2;
  assign port_bytes[3] = bus.debug_port3;
  assign port_bytes[4] = bus.debug_port4;
  assign port_bytes[5] = bus.debug_port5;
  assign port_bytes[6] = bus.debug_port6;
  assign port_bytes[7] = bus.debug_port7;

  assign chk_d = port_bytes[1] ^ port_bytes[2] ^ port_bytes[3] ^ port_bytes[4]
               ^ port_bytes[5] ^ port_bytes[6] ^ port_bytes[7];

  genvar gi;
  generate
    for (gi = 1; gi <= 7; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (!nreset) begin
          shadow_q[gi] <= 8'h00;
        end else if (load) begin
          shadow_q[gi] <= port_bytes[gi];
        end
      end
    end

    // Frame byte table indexed by byte_idx; entries past the checksum are never selected.
    for (gi = 0; gi < 16; gi++) begin : g_frame
      if (gi == 0) begin : g_sync
        assign frame_bytes[gi] = SYNC_BYTE;
      end else if (gi <= 7) begin : g_port
        assign frame_bytes[gi] = shadow_q[gi];
      end else if (gi == 8) begin : g_chk
        assign frame_bytes[gi] = chk_q;
      end else begin : g_pad
        assign frame_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          load       = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (byte_idx_q == 4'd8) begin
            byte_idx_d   = '0;
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = START;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_bytes[byte_idx_d][bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Only a new rising capture while a frame is in flight is an overrun; a held request is not.
  assign overrun_d = (state_q != IDLE) && bus.capture && !capture_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      capture_q    <= 1'b0;
      chk_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      tx_q         <= tx_d;
      busy_q       <= (state_d != IDLE);
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      capture_q    <= bus.capture;
      if (load) begin
        chk_q <= chk_d;
      end
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: expected frame bytes are queued when a capture is
// driven and popped as a UART decoder recovers bytes from tx.
module tb_debug_frame_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;

  debug_frame_tx_if dif();

  debug_frame_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (dif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // Free-running activity counters, read as differences by the stimulus.
  int   cyc = 0;
  int   busy_cycles = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;
  int   tx_low_cnt = 0;
  int   last_done_cyc = 0;
  int   gap_after_done = -1;
  logic prev_tx = 1'b1;
  logic done_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dif.busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (dif.overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (dif.tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    if (dif.frame_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      done_pending  <= 1'b1;
    end else if (done_pending && prev_tx === 1'b1 && dif.tx === 1'b0) begin
      gap_after_done <= cyc - last_done_cyc;
      done_pending   <= 1'b0;
    end
    prev_tx <= dif.tx;
  end

  task automatic check(input string tag, input int obs, input int want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic set_ports(input logic [55:0] p);
    dif.debug_port1 = p[7:0];
    dif.debug_port2 = p[15:8];
    dif.debug_port3 = p[23:16];
    dif.debug_port4 = p[31:24];
    dif.debug_port5 = p[39:32];
    dif.debug_port6 = p[47:40];
    dif.debug_port7 = p[55:48];
  endtask

  task automatic push_frame(input logic [55:0] p);
    logic [7:0] chk;
    chk = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(p[8*i +: 8]);
      chk = chk ^ p[8*i +: 8];
    end
    exp_q.push_back(chk);
  endtask

  task automatic pulse_capture(output int cap_cyc);
    @(negedge clk);
    dif.capture = 1'b1;
    cap_cyc = cyc + 1;
    @(negedge clk);
    dif.capture = 1'b0;
  endtask

  // Decodes nine UART bytes, sampling each bit near its centre.
  task automatic recv_frame(input string tag);
    logic       got_start;
    logic [7:0] got;
    logic [7:0] want;
    logic       stop_bit;
    for (int k = 0; k < 9; k++) begin
      got_start = 1'b0;
      for (int t = 0; t < 500 && !got_start; t++) begin
        @(negedge clk);
        if (dif.tx === 1'b0) got_start = 1'b1;
      end
      check($sformatf("%s_start%0d", tag, k), int'(got_start), 1);
      if (!got_start) begin
        exp_q.delete();
        return;
      end
      repeat (CPB/2) @(negedge clk);
      check($sformatf("%s_startbit%0d", tag, k), int'(dif.tx), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        got[i] = dif.tx;
      end
      repeat (CPB) @(negedge clk);
      stop_bit = dif.tx;
      check($sformatf("%s_qnonempty%0d", tag, k), int'(exp_q.size() > 0), 1);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      $display("[TB] %s byte %0d: got 0x%02h expected 0x%02h", tag, k, got, want);
      check($sformatf("%s_byte%0d", tag, k), int'(got), int'(want));
      check($sformatf("%s_stop%0d", tag, k), int'(stop_bit), 1);
    end
  endtask

  initial begin
    int c0;
    int base_busy, base_done, base_ovr, base_low;

    dif.capture = 1'b0;
    set_ports(56'h0);

    // 1: reset and idle line
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("rst_tx", int'(dif.tx), 1);
    check("rst_busy", int'(dif.busy), 0);
    check("rst_frame_done", int'(dif.frame_done), 0);
    check("rst_overrun", int'(dif.overrun), 0);
    base_low = tx_low_cnt;
    repeat (50) @(negedge clk);
    check("idle_tx_low_cycles", tx_low_cnt - base_low, 0);

    // 2: basic frame, checksum 7F
    set_ports(56'h40201008040201);
    push_frame(56'h40201008040201);
    base_busy = busy_cycles;
    base_done = done_cnt;
    fork
      recv_frame("f2");
      pulse_capture(c0);
    join
    repeat (10) @(negedge clk);
    check("f2_busy_cycles", busy_cycles - base_busy, 90*CPB);
    check("f2_done_count", done_cnt - base_done, 1);
    check("f2_done_offset", last_done_cyc - c0, 90*CPB);

    // 3: ports change mid-frame, snapshot must hold
    set_ports(56'h1122334455AA5A);
    push_frame(56'h1122334455AA5A);
    fork
      recv_frame("f3");
      begin
        pulse_capture(c0);
        repeat (19) @(negedge clk);
        set_ports(56'hFFFFFFFFFFFFFF);
      end
    join
    repeat (10) @(negedge clk);

    // 4: capture during a frame is rejected with one overrun pulse
    set_ports(56'h3C96E1870F0FC3);
    push_frame(56'h3C96E1870F0FC3);
    base_done = done_cnt;
    base_ovr  = ovr_cnt;
    fork
      recv_frame("f4");
      begin
        pulse_capture(c0);
        repeat (99) @(negedge clk);
        dif.capture = 1'b1;
        @(negedge clk);
        dif.capture = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("f4_overrun_cycles", ovr_cnt - base_ovr, 1);
    base_low = tx_low_cnt;
    repeat (400) @(negedge clk);
    check("f4_no_second_frame", tx_low_cnt - base_low, 0);
    check("f4_done_count", done_cnt - base_done, 1);

    // 5: held capture; 720 cycles admits exactly two frames (a third would start at 722)
    set_ports(56'h0123456789ABCD);
    push_frame(56'h0123456789ABCD);
    push_frame(56'h0123456789ABCD);
    base_done = done_cnt;
    base_ovr  = ovr_cnt;
    fork
      begin
        recv_frame("f5a");
        recv_frame("f5b");
      end
      begin
        @(negedge clk);
        dif.capture = 1'b1;
        repeat (720) @(negedge clk);
        dif.capture = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    base_low = tx_low_cnt;
    repeat (50) @(negedge clk);
    check("f5_no_third_frame", tx_low_cnt - base_low, 0);
    check("f5_done_count", done_cnt - base_done, 2);
    check("f5_overrun_count", ovr_cnt - base_ovr, 0);
    check("f5_gap_after_done", gap_after_done, 1);

    // 6: reset mid-frame abandons it; a following frame is complete
    set_ports(56'hDEADBEEFCAFE42);
    push_frame(56'hDEADBEEFCAFE42);
    base_done = done_cnt;
    base_ovr  = ovr_cnt;
    pulse_capture(c0);
    repeat (149) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    check("f6_rst_tx", int'(dif.tx), 1);
    check("f6_rst_busy", int'(dif.busy), 0);
    check("f6_rst_frame_done", int'(dif.frame_done), 0);
    nreset = 1'b1;
    repeat (20) @(negedge clk);
    check("f6_abort_done_count", done_cnt - base_done, 0);
    check("f6_abort_overrun_count", ovr_cnt - base_ovr, 0);
    exp_q.delete();
    set_ports(56'h5566778899AABB);
    push_frame(56'h5566778899AABB);
    fork
      recv_frame("f6");
      pulse_capture(c0);
    join
    repeat (10) @(negedge clk);
    check("f6_done_count", done_cnt - base_done, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
